ram_async_32x32: RTL and testbench



---
 rtl/ram_async_32x32_if.sv | 40 ++++
 rtl/ram_async_32x32.sv | 89 ++++++++
 tb/tb_ram_async_32x32.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ram_async_32x32_if.sv
// ram_async_32x32_if
// Bus bundle for the 32x32 asynchronous-read scratch RAM.
//   address    : word address shared by read and write
//   writeOn    : write enable, sampled on the rising clock edge
//   data_in    : write data
//   data_out   : combinational read of the addressed word
//   parity_err : stored-parity mismatch flag (only with RAM_ASYNC_PARITY_EN)
// master modport drives the request side; slave modport is the RAM.
interface ram_async_32x32_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   logic [ADDR_WIDTH-1:0] address;
   logic                  writeOn;
   logic [DATA_WIDTH-1:0] data_in;
   logic [DATA_WIDTH-1:0] data_out;
`ifdef RAM_ASYNC_PARITY_EN
   logic                  parity_err;
`endif

   modport master (
      output address,
      output writeOn,
      output data_in,
`ifdef RAM_ASYNC_PARITY_EN
      input  parity_err,
`endif
      input  data_out
   );

   modport slave (
      input  address,
      input  writeOn,
      input  data_in,
`ifdef RAM_ASYNC_PARITY_EN
      output parity_err,
`endif
      output data_out
   );
endinterface

// File: rtl/ram_async_32x32.sv
// ram_async_32x32
// Single-port DEPTH x DATA_WIDTH RAM: clocked writes, combinational reads.
// Ports:
//   clk  : write clock, rising edge active
//   rst  : asynchronous active-high reset, clears every word
//   bus  : ram_async_32x32_if.slave (address, writeOn, data_in, data_out,
//          parity_err when enabled)
// Optional feature macro: RAM_ASYNC_PARITY_EN adds one even-parity bit per
// word and the parity_err output.
module ram_async_32x32 #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int DEPTH      = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   ram_async_32x32_if.slave        bus
);

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic                  in_range_s;
   logic [DATA_WIDTH-1:0] data_out_s;

   // Even parity: the stored bit makes the XOR of data plus parity zero.
   function automatic logic even_parity(input logic [DATA_WIDTH-1:0] d);
      return ^d;
   endfunction

   // Range check only exists when the array does not fill the address space.
   generate
      if (DEPTH < (1 << ADDR_WIDTH)) begin : g_partial
         assign in_range_s = (32'(bus.address) < 32'(DEPTH));
      end else begin : g_full
         assign in_range_s = 1'b1;
      end
   endgenerate

   // Storage: async clear of all words, single-word write per rising edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {DATA_WIDTH{1'b0}};
         end
      end else if (bus.writeOn && in_range_s) begin
         mem_r[bus.address] <= bus.data_in;
      end
   end

   // Combinational read; out-of-range addresses read as zero.
   always_comb begin
      data_out_s = {DATA_WIDTH{1'b0}};
      if (in_range_s) begin
         data_out_s = mem_r[bus.address];
      end else begin
         data_out_s = {DATA_WIDTH{1'b0}};
      end
   end

   assign bus.data_out = data_out_s;

`ifdef RAM_ASYNC_PARITY_EN
   logic par_r [DEPTH];
   logic parity_err_s;

   // Parity storage mirrors the data array's reset and write behaviour.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            par_r[i] <= 1'b0;
         end
      end else if (bus.writeOn && in_range_s) begin
         par_r[bus.address] <= even_parity(bus.data_in);
      end
   end

   // Mismatch between the addressed word and its stored parity bit.
   always_comb begin
      parity_err_s = 1'b0;
      if (in_range_s) begin
         parity_err_s = ^{mem_r[bus.address], par_r[bus.address]};
      end else begin
         parity_err_s = 1'b0;
      end
   end

   assign bus.parity_err = parity_err_s;
`endif

endmodule

// File: tb/tb_ram_async_32x32.sv
// tb_ram_async_32x32
// Self-checking bench: directed cases plus randomized read/write traffic
// compared against a plain array model of the RAM.
module tb_ram_async_32x32;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   logic [31:0] model_mem [32];

   ram_async_32x32_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

   ram_async_32x32 #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_value(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk_parity(input string tag);
`ifdef RAM_ASYNC_PARITY_EN
      chk_value(tag, {31'd0, bus.parity_err}, 32'd0);
`endif
   endtask

   // Clear the model the way the reset clears the array.
   task automatic model_clear();
      for (int i = 0; i < 32; i++) model_mem[i] = 32'd0;
   endtask

   // Drive one cycle at the falling edge, check pre-edge read, then
   // check post-edge read and update the model.
   task automatic do_cycle(input logic [4:0] a, input logic we,
                           input logic [31:0] d, input string tag);
      @(negedge clk);
      bus.address = a;
      bus.writeOn = we;
      bus.data_in = d;
      #1;
      chk_value({tag, "_pre"}, bus.data_out, model_mem[a]);
      @(posedge clk);
      if (we) model_mem[a] = d;
      #1;
      chk_value({tag, "_post"}, bus.data_out, model_mem[a]);
      chk_parity({tag, "_par"});
   endtask

   task automatic read_at(input logic [4:0] a, input logic [31:0] exp,
                          input string tag);
      bus.writeOn = 1'b0;
      bus.address = a;
      #1;
      chk_value(tag, bus.data_out, exp);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b0;
      bus.address = 5'd0;
      bus.writeOn = 1'b0;
      bus.data_in = 32'd0;
      #1 rst = 1'b1;
      model_clear();
      #2;
      chk_value("reset_dout", bus.data_out, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Sweep after reset: everything reads zero.
      for (int i = 0; i < 32; i++) read_at(5'(i), 32'd0, "sweep_zero");

      // Directed writes.
      do_cycle(5'd3,  1'b1, 32'hDEADBEEF, "wr_a3");
      do_cycle(5'd31, 1'b1, 32'h12345678, "wr_a31");
      @(negedge clk);
      read_at(5'd3,  32'hDEADBEEF, "rd_a3");
      read_at(5'd31, 32'h12345678, "rd_a31");
      read_at(5'd0,  32'd0, "rd_a0");
      read_at(5'd30, 32'd0, "rd_a30");

      // Write latency: old value before the edge, new immediately after.
      do_cycle(5'd5, 1'b1, 32'hAAAA5555, "wr_a5");

      // Disabled writes leave contents alone across several edges.
      for (int k = 0; k < 4; k++) do_cycle(5'd3, 1'b0, 32'hFFFFFFFF, "hold_a3");

      // Parity check on a single-bit word.
      do_cycle(5'd7, 1'b1, 32'h00000001, "wr_a7");

      // Randomized traffic against the model.
      for (int n = 0; n < 300; n++) begin
         do_cycle(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                  $urandom, "rand");
      end

      // Mid-cycle reset with a write pending: clears immediately.
      do_cycle(5'd3,  1'b1, 32'hDEADBEEF, "pre_rst_a3");
      do_cycle(5'd31, 1'b1, 32'h12345678, "pre_rst_a31");
      @(posedge clk);
      #2;
      bus.address = 5'd31;
      bus.writeOn = 1'b1;
      bus.data_in = 32'hCAFEF00D;
      rst = 1'b1;
      model_clear();
      #1;
      chk_value("rst_mid_dout", bus.data_out, 32'd0);
      @(posedge clk);
      #1;
      chk_value("rst_edge_nowrite", bus.data_out, 32'd0);
      @(negedge clk);
      bus.writeOn = 1'b0;
      rst = 1'b0;
      read_at(5'd3,  32'd0, "post_rst_a3");
      read_at(5'd31, 32'd0, "post_rst_a31");
      chk_parity("post_rst_par");

      // First write after release lands on the next rising edge.
      do_cycle(5'd9, 1'b1, 32'h0BADF00D, "first_wr");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
